// File: rtl/timer_pkg.sv
// Shared types and default widths for the multi-channel timer.
package timer_pkg;

   localparam int TIMER_NBITS_DEF    = 32;
   localparam int TIMER_PSC_BITS_DEF = 8;

   typedef enum logic {
      PERIODIC = 1'b0,
      ONESHOT  = 1'b1
   } timer_mode_t;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_RUN  = 2'd1,
      T_DONE = 2'd2
   } timer_state_t;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: config registers, run/stop FSM, up-counter and tick flop.
//  state  | meaning
//  T_IDLE | stopped, count held
//  T_RUN  | counting one per step toward the active terminal value
//  T_DONE | one-shot reached terminal, count holds terminal value
module timer_chan
   import timer_pkg::*;
#(
   parameter int NBITS = TIMER_NBITS_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [NBITS-1:0] cfg_ini,
   input  logic [NBITS-1:0] cfg_rst,
   input  timer_mode_t      cfg_mode,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   output logic             tick,
   output logic             busy,
   output logic             done,
   output logic [NBITS-1:0] count
);

   logic [NBITS-1:0] ini_q, ini_d;
   logic [NBITS-1:0] term_q, term_d;
   timer_mode_t      mode_q, mode_d;
   logic [NBITS-1:0] act_term_q, act_term_d;
   timer_mode_t      act_mode_q, act_mode_d;
   timer_state_t     state_q, state_d;
   logic [NBITS-1:0] count_q, count_d;
   logic             tick_q, tick_d;

   // Terminal value and mode are snapshotted at start/reload so a
   // reconfiguration never changes the period currently in progress.
   always_comb begin
      ini_d      = ini_q;
      term_d     = term_q;
      mode_d     = mode_q;
      act_term_d = act_term_q;
      act_mode_d = act_mode_q;
      state_d    = state_q;
      count_d    = count_q;
      tick_d     = 1'b0;
      if (cfg_we) begin
         ini_d  = cfg_ini;
         term_d = cfg_rst;
         mode_d = cfg_mode;
      end
      if (stop) begin
         state_d = T_IDLE;
      end else if (start) begin
         state_d    = T_RUN;
         count_d    = ini_q;
         act_term_d = term_q;
         act_mode_d = mode_q;
      end else if (state_q == T_RUN && step) begin
         if (count_q == act_term_q) begin
            tick_d = 1'b1;
            if (act_mode_q == PERIODIC) begin
               count_d    = ini_q;
               act_term_d = term_q;
               act_mode_d = mode_q;
            end else begin
               state_d = T_DONE;
            end
         end else begin
            count_d = count_q + NBITS'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ini_q      <= '0;
         term_q     <= '0;
         mode_q     <= PERIODIC;
         act_term_q <= '0;
         act_mode_q <= PERIODIC;
         state_q    <= T_IDLE;
         count_q    <= '0;
         tick_q     <= 1'b0;
      end else begin
         ini_q      <= ini_d;
         term_q     <= term_d;
         mode_q     <= mode_d;
         act_term_q <= act_term_d;
         act_mode_q <= act_mode_d;
         state_q    <= state_d;
         count_q    <= count_d;
         tick_q     <= tick_d;
      end
   end

   assign tick  = tick_q;
   assign busy  = (state_q == T_RUN);
   assign done  = (state_q == T_DONE);
   assign count = count_q;

endmodule

// File: rtl/timer_mc.sv
// Multi-channel up-counting timer: config decode, shared step source, output packing.
// Optional shared prescaler and psc_div port enabled by defining TIMER_PRESCALE_EN.
module timer_mc
   import timer_pkg::*;
#(
   parameter int NBITS    = TIMER_NBITS_DEF,
   parameter int NCH      = 4,
   parameter int CHW      = (NCH > 1) ? $clog2(NCH) : 1,
   parameter int PSC_BITS = TIMER_PSC_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_we,
   input  logic [CHW-1:0]       cfg_ch,
   input  logic [NBITS-1:0]     cfg_ini,
   input  logic [NBITS-1:0]     cfg_rst,
   input  logic                 cfg_mode,
   input  logic [NCH-1:0]       start,
   input  logic [NCH-1:0]       stop,
`ifdef TIMER_PRESCALE_EN
   input  logic [PSC_BITS-1:0]  psc_div,
`endif
   output logic [NCH-1:0]       tick,
   output logic [NCH-1:0]       busy,
   output logic [NCH-1:0]       done,
   output logic [NCH*NBITS-1:0] count
);

   if (NCH < 1 || NCH > 16) begin : g_bad_nch
      $error("timer_mc: NCH must be in 1..16");
   end
   if (PSC_BITS < 1) begin : g_bad_psc
      $error("timer_mc: PSC_BITS must be at least 1");
   end

   logic step;

`ifdef TIMER_PRESCALE_EN
   logic [PSC_BITS-1:0] psc_q, psc_d;

   // Free-running divider shared by all channels; not aligned to any start.
   always_comb begin
      step  = (psc_q == psc_div);
      psc_d = step ? '0 : psc_q + PSC_BITS'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) psc_q <= '0;
      else       psc_q <= psc_d;
   end
`else
   assign step = 1'b1;
`endif

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic we_i;
      // Out-of-range channel indices match no instance and are dropped.
      assign we_i = cfg_we && (cfg_ch == CHW'(i));

      timer_chan #(.NBITS(NBITS)) u_chan (
         .clk      (clk),
         .reset    (reset),
         .cfg_we   (we_i),
         .cfg_ini  (cfg_ini),
         .cfg_rst  (cfg_rst),
         .cfg_mode (timer_mode_t'(cfg_mode)),
         .start    (start[i]),
         .stop     (stop[i]),
         .step     (step),
         .tick     (tick[i]),
         .busy     (busy[i]),
         .done     (done[i]),
         .count    (count[i*NBITS +: NBITS])
      );
   end

endmodule

// File: tb/tb_timer_mc.sv
// Scoreboard bench for timer_mc (NCH=3): stimulus queues expected state and tick cycles,
// a negedge monitor pops and compares them.
module tb_timer_mc;

   localparam int NB = 32;
   localparam int NC = 3;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_we;
   logic [CW-1:0] cfg_ch;
   logic [NB-1:0] cfg_ini;
   logic [NB-1:0] cfg_rst;
   logic          cfg_mode;
   logic [NC-1:0] start;
   logic [NC-1:0] stop;
`ifdef TIMER_PRESCALE_EN
   logic [7:0]    psc_div;
`endif
   logic [NC-1:0]    tick;
   logic [NC-1:0]    busy;
   logic [NC-1:0]    done;
   logic [NC*NB-1:0] count;

   timer_mc #(.NBITS(NB), .NCH(NC)) dut (
      .clk      (clk),
      .reset    (reset),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_ini  (cfg_ini),
      .cfg_rst  (cfg_rst),
      .cfg_mode (cfg_mode),
      .start    (start),
      .stop     (stop),
`ifdef TIMER_PRESCALE_EN
      .psc_div  (psc_div),
`endif
      .tick     (tick),
      .busy     (busy),
      .done     (done),
      .count    (count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          ch;
      logic [31:0] cnt;
      logic        b;
      logic        d;
      logic        t;
   } chk_t;

   chk_t chk_q[$];
   int   tq[NC][$];
   int   checks = 0;
   int   errors = 0;

   always @(negedge clk) begin
      chk_t        e;
      logic [31:0] ac;
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
         e  = chk_q.pop_front();
         ac = count[e.ch*NB +: NB];
         checks++;
         if (e.cyc != cyc || ac !== e.cnt || busy[e.ch] !== e.b ||
             done[e.ch] !== e.d || tick[e.ch] !== e.t) begin
            errors++;
            $display("FAIL state ch%0d cyc%0d (due %0d): got cnt=%h busy=%b done=%b tick=%b, want cnt=%h busy=%b done=%b tick=%b",
                     e.ch, cyc, e.cyc, ac, busy[e.ch], done[e.ch], tick[e.ch], e.cnt, e.b, e.d, e.t);
         end
      end
      for (int c = 0; c < NC; c++) begin
         if (tick[c] === 1'b1) begin
            checks++;
            if (tq[c].size() > 0 && tq[c][0] == cyc) begin
               void'(tq[c].pop_front());
            end else begin
               errors++;
               $display("FAIL tick ch%0d: got tick at cyc %0d, next expected at %0d",
                        c, cyc, (tq[c].size() > 0) ? tq[c][0] : -1);
               if (tq[c].size() > 0 && tq[c][0] < cyc) void'(tq[c].pop_front());
            end
         end else if (tq[c].size() > 0 && tq[c][0] <= cyc) begin
            checks++;
            errors++;
            $display("FAIL tick ch%0d: got no tick at cyc %0d, required tick at %0d",
                     c, cyc, tq[c][0]);
            void'(tq[c].pop_front());
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_st(input int ch, input logic [31:0] c, input logic b,
                         input logic d, input logic t);
      chk_t e;
      e.cyc = cyc; e.ch = ch; e.cnt = c; e.b = b; e.d = d; e.t = t;
      chk_q.push_back(e);
   endtask

   task automatic exp_tick(input int ch, input int at);
      tq[ch].push_back(at);
   endtask

   task automatic cfg(input int ch, input logic [31:0] ini, input logic [31:0] term,
                      input logic mode);
      cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_ini = ini; cfg_rst = term; cfg_mode = mode;
      nxt();
      cfg_we = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by cyc %0d, required finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      int exp5[8];
      exp5 = '{3, 4, 5, 100, 101, 100, 101, 100};

      reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_ini = '0; cfg_rst = '0;
      cfg_mode = 1'b0; start = '1; stop = '0;
`ifdef TIMER_PRESCALE_EN
      psc_div = '0;
`endif

      // reset held two cycles while start is requested everywhere
      nxt();
      for (int c = 0; c < NC; c++) exp_st(c, 32'h0, 1'b0, 1'b0, 1'b0);
      nxt();
      for (int c = 0; c < NC; c++) exp_st(c, 32'h0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0; start = '0;
      nxt();
      for (int c = 0; c < NC; c++) exp_st(c, 32'h0, 1'b0, 1'b0, 1'b0);

      // periodic ch0: 3,4,5,3,...
      cfg(0, 32'd3, 32'd5, 1'b0);
      start = 3'b001; nxt(); start = '0; e0 = cyc;
      exp_tick(0, e0 + 3); exp_tick(0, e0 + 6); exp_tick(0, e0 + 9);
      for (int k = 0; k < 10; k++) begin
         exp_st(0, 32'(3 + k % 3), 1'b1, 1'b0, (k > 0 && k % 3 == 0));
         nxt();
      end
      stop = 3'b001; nxt(); stop = '0;
      exp_st(0, 32'd4, 1'b0, 1'b0, 1'b0);
      nxt();
      exp_st(0, 32'd4, 1'b0, 1'b0, 1'b0);

      // one-shot with wrap on ch1
      cfg(1, 32'hFFFF_FFFE, 32'h1, 1'b1);
      start = 3'b010; nxt(); start = '0; e0 = cyc;
      exp_tick(1, e0 + 4);
      for (int k = 0; k < 7; k++) begin
         exp_st(1, (k <= 3) ? 32'hFFFF_FFFE + 32'(k) : 32'h1, (k < 4), (k >= 4), (k == 4));
         nxt();
      end

      // ch2 conflicts: start+stop together, restart mid-run, restart on terminal
      cfg(2, 32'd10, 32'd20, 1'b0);
      start = 3'b100; nxt(); start = '0;
      for (int k = 0; k < 4; k++) begin
         exp_st(2, 32'(10 + k), 1'b1, 1'b0, 1'b0);
         nxt();
      end
      exp_st(2, 32'd14, 1'b1, 1'b0, 1'b0);
      start = 3'b100; stop = 3'b100; nxt(); start = '0; stop = '0;
      exp_st(2, 32'd14, 1'b0, 1'b0, 1'b0);
      nxt();
      exp_st(2, 32'd14, 1'b0, 1'b0, 1'b0);
      start = 3'b100; nxt(); start = '0;
      for (int k = 0; k < 5; k++) begin
         exp_st(2, 32'(10 + k), 1'b1, 1'b0, 1'b0);
         nxt();
      end
      start = 3'b100; nxt(); start = '0;
      for (int k = 0; k < 10; k++) begin
         exp_st(2, 32'(10 + k), 1'b1, 1'b0, 1'b0);
         nxt();
      end
      exp_st(2, 32'd20, 1'b1, 1'b0, 1'b0);
      start = 3'b100; nxt(); start = '0;
      exp_st(2, 32'd10, 1'b1, 1'b0, 1'b0);
      stop = 3'b100; nxt(); stop = '0;
      exp_st(2, 32'd10, 1'b0, 1'b0, 1'b0);

      // out-of-range cfg_ch is ignored; reconfig while running keeps old period
      cfg(3, 32'd77, 32'd78, 1'b1);
      start = 3'b001; nxt(); start = '0; e0 = cyc;
      exp_tick(0, e0 + 3); exp_tick(0, e0 + 5); exp_tick(0, e0 + 7);
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_ini = 32'd100; cfg_rst = 32'd101; cfg_mode = 1'b0;
      for (int k = 0; k < 8; k++) begin
         exp_st(0, 32'(exp5[k]), 1'b1, 1'b0, (k == 3 || k == 5 || k == 7));
         nxt();
         if (k == 0) cfg_we = 1'b0;
      end
      stop = 3'b001; nxt(); stop = '0;
      exp_st(0, 32'd101, 1'b0, 1'b0, 1'b0);

      // config and start on the same edge: start takes the old ini
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_ini = 32'd50; cfg_rst = 32'd51; cfg_mode = 1'b0;
      start = 3'b110; nxt(); cfg_we = 1'b0; start = '0;
      exp_st(1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
      exp_st(2, 32'd10, 1'b1, 1'b0, 1'b0);
      stop = 3'b110; nxt(); stop = '0;
      exp_st(1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      exp_st(2, 32'd10, 1'b0, 1'b0, 1'b0);
      start = 3'b010; nxt(); start = '0;
      exp_st(1, 32'd50, 1'b1, 1'b0, 1'b0);
      stop = 3'b010; nxt(); stop = '0;
      exp_st(1, 32'd50, 1'b0, 1'b0, 1'b0);

`ifdef TIMER_PRESCALE_EN
      // divider was idle at 0, so the first step lands four edges after start
      cfg(0, 32'd0, 32'd1, 1'b0);
      psc_div = 8'd3; start = 3'b001; nxt(); start = '0; e0 = cyc;
      exp_tick(0, e0 + 7); exp_tick(0, e0 + 15); exp_tick(0, e0 + 23);
      for (int k = 0; k < 25; k++) begin
         exp_st(0, 32'(((k + 1) / 4) % 2), 1'b1, 1'b0, (k == 7 || k == 15 || k == 23));
         nxt();
      end
      stop = 3'b001; psc_div = 8'd0; nxt(); stop = '0;
`endif

      repeat (3) nxt();
      for (int c = 0; c < NC; c++) begin
         checks++;
         if (tq[c].size() != 0) begin
            errors++;
            $display("FAIL tick_left ch%0d: got %0d ticks outstanding, required 0",
                     c, tq[c].size());
         end
      end
      checks++;
      if (chk_q.size() != 0) begin
         errors++;
         $display("FAIL state_left: got %0d checks outstanding, required 0", chk_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
